// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, occupancy flags and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int ADDR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] PTR_INC = CNT_W'(1);
  localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LVL);

  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] ram_q;
  logic              out_cleared;
  logic              wr_accept;
  logic              rd_accept;
  logic              wr_reject;
  logic              rd_reject;

  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_accept = w_en & ~full  & ~flush & ~rst;
  assign rd_accept = r_en & ~empty & ~flush & ~rst;
  assign wr_reject = w_en & full  & ~flush;
  assign rd_reject = r_en & empty & ~flush;

  // The RAM read register has no reset, so data_out is masked to zero until the first read after reset.
  assign data_out = out_cleared ? '0 : ram_q;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_accept),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_valid    <= 1'b0;
      out_cleared <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + PTR_INC;
        if (rd_accept) rd_ptr <= rd_ptr + PTR_INC;
      end
      rd_valid <= rd_accept;
      if (rd_accept) out_cleared <= 1'b0;
      // A fresh error event beats clr_err in the same cycle.
      overflow  <= wr_reject | (overflow  & ~clr_err);
      underflow <= rd_reject | (underflow & ~clr_err);
    end
  end

endmodule
